service_2_alarm_ring: RTL and testbench

SERVICE_2_ALARM_RING -- requirements
Module: service_2_alarm_ring

---
 rtl/service_2_alarm_ring.sv | 136 +++++++++++++
 tb/tb_service_2_alarm_ring.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/service_2_alarm_ring.sv
// Alarm ringer: stores a validated BCD alarm time, rings on match, supports
// a limited number of timed snoozes, auto-off after a ring timeout.
module service_2_alarm_ring #(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        finish2,
   input  logic [15:0] alarm,
   input  logic [15:0] cur_time,
   input  logic        sec_tick,
   input  logic        spdt3,
   input  logic        push_c,
   input  logic        push_u,
   output logic        ring,
   output logic [15:0] led,
   output logic        armed,
   output logic [1:0]  snooze_cnt,
   output logic [15:0] alarm_reg
);

   localparam int RW = $clog2(RING_SEC + 1);
   localparam int SW = $clog2(SNOOZE_SEC + 1);
   localparam logic [RW-1:0] RING_MAX   = RW'(RING_SEC);
   localparam logic [RW-1:0] RING_LAST  = RW'(RING_SEC - 1);
   localparam logic [SW-1:0] SNZ_MAX    = SW'(SNOOZE_SEC);
   localparam logic [SW-1:0] SNZ_LAST   = SW'(SNOOZE_SEC - 1);
   localparam logic [1:0]    SNZ_LIMIT  = 2'(MAX_SNOOZE);

   typedef enum logic [2:0] {IDLE, ARMED, RINGING, SNOOZE, DONE} state_t;

   state_t         state, state_n;
   logic [RW-1:0]  ring_timer, ring_timer_n;
   logic [SW-1:0]  snz_timer, snz_timer_n;
   logic           blink, blink_n;
   logic [15:0]    alarm_n;
   logic [1:0]     cnt_n;
   logic           ring_n, armed_n;
   logic [15:0]    led_n;
   logic           alarm_ok;

   // HH must be 00..23 and MM 00..59, every nibble a decimal digit
   always_comb begin
      alarm_ok = (alarm[15:12] <= 4'd2) && (alarm[11:8] <= 4'd9) &&
                 (alarm[7:4] <= 4'd5) && (alarm[3:0] <= 4'd9) &&
                 !((alarm[15:12] == 4'd2) && (alarm[11:8] > 4'd3));
   end

   always_comb begin
      state_n      = state;
      alarm_n      = alarm_reg;
      cnt_n        = snooze_cnt;
      ring_timer_n = ring_timer;
      snz_timer_n  = snz_timer;
      blink_n      = blink;
      case (state)
         IDLE: ;
         ARMED: begin
            if (spdt3 && (cur_time == alarm_reg)) begin
               state_n      = RINGING;
               ring_timer_n = '0;
               blink_n      = 1'b0;
            end
         end
         RINGING: begin
            if (sec_tick) begin
               blink_n = ~blink;
               if (ring_timer < RING_MAX) ring_timer_n = ring_timer + 1'b1;
            end
            if (!spdt3 || push_c) begin
               state_n = DONE;
            end else if (push_u && (snooze_cnt < SNZ_LIMIT)) begin
               state_n     = SNOOZE;
               cnt_n       = snooze_cnt + 2'd1;
               snz_timer_n = '0;
            end else if (sec_tick && (ring_timer >= RING_LAST)) begin
               state_n = DONE;
            end
         end
         SNOOZE: begin
            if (sec_tick && (snz_timer < SNZ_MAX)) snz_timer_n = snz_timer + 1'b1;
            if (!spdt3 || push_c) begin
               state_n = DONE;
            end else if (sec_tick && (snz_timer >= SNZ_LAST)) begin
               state_n      = RINGING;
               ring_timer_n = '0;
               blink_n      = 1'b0;
            end
         end
         DONE: begin
            // wait for the minute to roll over so the same match cannot retrigger
            if (cur_time != alarm_reg) begin
               state_n = ARMED;
               cnt_n   = 2'd0;
            end
         end
         default: state_n = IDLE;
      endcase
      if (finish2 && alarm_ok) begin
         state_n = ARMED;
         alarm_n = alarm;
         cnt_n   = 2'd0;
      end
      ring_n  = (state_n == RINGING);
      led_n   = ((state_n == RINGING) && blink_n) ? 16'hFFFF : 16'h0000;
      armed_n = (state_n != IDLE) && spdt3;
   end

   // all outputs are registered copies of the next-state decode
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         alarm_reg  <= 16'h0000;
         snooze_cnt <= 2'd0;
         ring_timer <= '0;
         snz_timer  <= '0;
         blink      <= 1'b0;
         ring       <= 1'b0;
         led        <= 16'h0000;
         armed      <= 1'b0;
      end else begin
         state      <= state_n;
         alarm_reg  <= alarm_n;
         snooze_cnt <= cnt_n;
         ring_timer <= ring_timer_n;
         snz_timer  <= snz_timer_n;
         blink      <= blink_n;
         ring       <= ring_n;
         led        <= led_n;
         armed      <= armed_n;
      end
   end

endmodule

// File: tb/tb_service_2_alarm_ring.sv
// Directed bench for service_2_alarm_ring with short timer parameters.
module tb_service_2_alarm_ring;

   logic        clk;
   logic        resetn;
   logic        finish2;
   logic [15:0] alarm;
   logic [15:0] cur_time;
   logic        sec_tick;
   logic        spdt3;
   logic        push_c;
   logic        push_u;
   logic        ring;
   logic [15:0] led;
   logic        armed;
   logic [1:0]  snooze_cnt;
   logic [15:0] alarm_reg;

   int compared   = 0;
   int mismatched = 0;

   service_2_alarm_ring #(.RING_SEC(4), .SNOOZE_SEC(3), .MAX_SNOOZE(3)) dut (
      .clk(clk), .resetn(resetn), .finish2(finish2), .alarm(alarm),
      .cur_time(cur_time), .sec_tick(sec_tick), .spdt3(spdt3),
      .push_c(push_c), .push_u(push_u), .ring(ring), .led(led),
      .armed(armed), .snooze_cnt(snooze_cnt), .alarm_reg(alarm_reg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sec_pulse();
      sec_tick = 1'b1;
      step();
      sec_tick = 1'b0;
   endtask

   task automatic load(input logic [15:0] value);
      alarm   = value;
      finish2 = 1'b1;
      step();
      finish2 = 1'b0;
   endtask

   task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      resetn = 1'b1; finish2 = 1'b0; alarm = 16'h0000; cur_time = 16'h0000;
      sec_tick = 1'b0; spdt3 = 1'b0; push_c = 1'b0; push_u = 1'b0;
      #1 resetn = 1'b0;
      #2;
      check_output("rst_ring", {15'd0, ring}, 16'd0);
      check_output("rst_led", led, 16'h0000);
      check_output("rst_armed", {15'd0, armed}, 16'd0);
      check_output("rst_cnt", {14'd0, snooze_cnt}, 16'd0);
      check_output("rst_alarm", alarm_reg, 16'h0000);
      #9 resetn = 1'b1;

      // load 09:38 and trigger on the match
      spdt3 = 1'b1; cur_time = 16'h0937;
      load(16'h0938);
      check_output("load_alarm", alarm_reg, 16'h0938);
      check_output("load_armed", {15'd0, armed}, 16'd1);
      step();
      check_output("premat_ring", {15'd0, ring}, 16'd0);
      cur_time = 16'h0938;
      step();
      check_output("match_ring", {15'd0, ring}, 16'd1);
      check_output("match_led", led, 16'h0000);
      sec_pulse();
      check_output("blink1", led, 16'hFFFF);
      sec_pulse();
      check_output("blink2", led, 16'h0000);
      sec_pulse();
      check_output("blink3", led, 16'hFFFF);
      check_output("tick3_ring", {15'd0, ring}, 16'd1);
      sec_pulse();
      check_output("autooff_ring", {15'd0, ring}, 16'd0);
      check_output("autooff_led", led, 16'h0000);
      step(); step(); step();
      check_output("noretrig", {15'd0, ring}, 16'd0);
      cur_time = 16'h0939;
      step();
      cur_time = 16'h0938;
      step();
      check_output("rearm_ring", {15'd0, ring}, 16'd1);

      // three snoozes each re-ring after three ticks
      for (int i = 1; i <= 3; i++) begin
         push_u = 1'b1; step(); push_u = 1'b0;
         check_output("snz_ring", {15'd0, ring}, 16'd0);
         check_output("snz_cnt", {14'd0, snooze_cnt}, 16'(i));
         sec_pulse(); sec_pulse();
         check_output("snz_wait", {15'd0, ring}, 16'd0);
         sec_pulse();
         check_output("snz_rering", {15'd0, ring}, 16'd1);
      end
      push_u = 1'b1; step(); push_u = 1'b0;
      check_output("snz4_ring", {15'd0, ring}, 16'd1);
      check_output("snz4_cnt", {14'd0, snooze_cnt}, 16'd3);
      push_c = 1'b1; step(); push_c = 1'b0;
      check_output("dismiss_ring", {15'd0, ring}, 16'd0);

      // invalid loads leave value and state alone (still DONE on 09:38)
      load(16'h2460);
      check_output("inv1_alarm", alarm_reg, 16'h0938);
      load(16'h0965);
      check_output("inv2_alarm", alarm_reg, 16'h0938);
      step();
      check_output("inv_state", {15'd0, ring}, 16'd0);

      // dismiss beats snooze
      cur_time = 16'h0939; step();
      cur_time = 16'h0938; step();
      check_output("prio_ringing", {15'd0, ring}, 16'd1);
      push_c = 1'b1; push_u = 1'b1; step(); push_c = 1'b0; push_u = 1'b0;
      check_output("prio_ring", {15'd0, ring}, 16'd0);
      check_output("prio_cnt", {14'd0, snooze_cnt}, 16'd0);

      // switch off during snooze ends the cycle
      cur_time = 16'h0939; step();
      cur_time = 16'h0938; step();
      push_u = 1'b1; step(); push_u = 1'b0;
      check_output("off_snz_cnt", {14'd0, snooze_cnt}, 16'd1);
      spdt3 = 1'b0; step();
      check_output("off_armed", {15'd0, armed}, 16'd0);
      spdt3 = 1'b1;
      sec_pulse(); sec_pulse(); sec_pulse();
      check_output("off_done", {15'd0, ring}, 16'd0);
      check_output("off_cnt", {14'd0, snooze_cnt}, 16'd1);

      // switch off while armed suppresses the trigger
      cur_time = 16'h0939; step();
      spdt3 = 1'b0; cur_time = 16'h0938; step(); step();
      check_output("armoff_ring", {15'd0, ring}, 16'd0);
      spdt3 = 1'b1; step();
      check_output("armon_ring", {15'd0, ring}, 16'd1);

      // asynchronous reset mid-ring, between edges
      #2 resetn = 1'b0;
      #1;
      check_output("arst_ring", {15'd0, ring}, 16'd0);
      check_output("arst_alarm", alarm_reg, 16'h0000);
      #1 resetn = 1'b1;
      cur_time = 16'h0000;
      step(); step(); step();
      check_output("idle_ring", {15'd0, ring}, 16'd0);
      check_output("idle_armed", {15'd0, armed}, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
